// File: rtl/fc.sv
// Binarized fully-connected output neuron: 192 serial +/-1 weights,
// six signed lanes per beat, one wrapped 32-bit dot product per frame.
module fc #(
    parameter int N_IN  = 192,
    parameter int LANES = 6,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          ivalid,
    input  logic [DW-1:0] din_0,
    input  logic [DW-1:0] din_1,
    input  logic [DW-1:0] din_2,
    input  logic [DW-1:0] din_3,
    input  logic [DW-1:0] din_4,
    input  logic [DW-1:0] din_5,
    input  logic          weight,
    input  logic          weight_en,
    output logic          ovalid,
    output logic [DW-1:0] dout
);
    localparam int BEATS = N_IN / LANES;
    localparam int BW    = $clog2(BEATS);
    localparam int IW    = $clog2(N_IN);

    logic [N_IN-1:0]  w_q, w_d;
    logic [DW-1:0]    acc_q, acc_d;
    logic [DW-1:0]    dout_q, dout_d;
    logic [BW-1:0]    beat_q, beat_d;
    logic             pend_q, pend_d;
    logic             ovalid_q, ovalid_d;

    logic [DW-1:0]    din [LANES];
    logic [IW-1:0]    base;
    logic [LANES-1:0] w_sel;
    logic [DW-1:0]    partial;

    assign din[0] = din_0;
    assign din[1] = din_1;
    assign din[2] = din_2;
    assign din[3] = din_3;
    assign din[4] = din_4;
    assign din[5] = din_5;

    // Beat b uses weights 6b..6b+5; bit set adds the lane, clear subtracts it.
    always_comb begin
        base    = IW'(beat_q) * IW'(LANES);
        w_sel   = w_q[base +: LANES];
        partial = '0;
        for (int k = 0; k < LANES; k++) begin
            partial = partial + (w_sel[k] ? din[k] : -din[k]);
        end
    end

    always_comb begin
        w_d      = w_q;
        acc_d    = acc_q;
        beat_d   = beat_q;
        pend_d   = pend_q;
        dout_d   = dout_q;
        ovalid_d = 1'b0;
        if (weight_en) begin
            // Shift in from the top so the first loaded bit ends at index 0.
            w_d    = {weight, w_q[N_IN-1:1]};
            acc_d  = '0;
            beat_d = '0;
            pend_d = 1'b0;
        end else begin
            pend_d = ivalid;
            if (pend_q) begin
                if (beat_q == BW'(BEATS - 1)) begin
                    dout_d   = acc_q + partial;
                    ovalid_d = 1'b1;
                    acc_d    = '0;
                    beat_d   = '0;
                end else begin
                    acc_d  = acc_q + partial;
                    beat_d = beat_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            w_q      <= '0;
            acc_q    <= '0;
            dout_q   <= '0;
            beat_q   <= '0;
            pend_q   <= 1'b0;
            ovalid_q <= 1'b0;
        end else begin
            w_q      <= w_d;
            acc_q    <= acc_d;
            dout_q   <= dout_d;
            beat_q   <= beat_d;
            pend_q   <= pend_d;
            ovalid_q <= ovalid_d;
        end
    end

    assign ovalid = ovalid_q;
    assign dout   = dout_q;
endmodule

// File: tb/tb_fc.sv
// Directed self-checking bench for the fc binarized output neuron.
module tb_fc;
    logic        clk = 1'b0;
    logic        rstn;
    logic        ivalid;
    logic [31:0] din_0, din_1, din_2, din_3, din_4, din_5;
    logic        weight;
    logic        weight_en;
    logic        ovalid;
    logic [31:0] dout;

    int checks   = 0;
    int failures = 0;
    int npulse   = 0;
    int ndouble  = 0;
    logic prev_ov = 1'b0;
    logic [31:0] res [$];

    fc dut (
        .clk(clk), .rstn(rstn), .ivalid(ivalid),
        .din_0(din_0), .din_1(din_1), .din_2(din_2),
        .din_3(din_3), .din_4(din_4), .din_5(din_5),
        .weight(weight), .weight_en(weight_en),
        .ovalid(ovalid), .dout(dout)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (ovalid === 1'b1) begin
            npulse++;
            res.push_back(dout);
            if (prev_ov === 1'b1) ndouble++;
        end
        prev_ov = ovalid;
    end

    task automatic set_din(input logic [5:0][31:0] v);
        din_0 = v[0]; din_1 = v[1]; din_2 = v[2];
        din_3 = v[3]; din_4 = v[4]; din_5 = v[5];
    endtask

    task automatic load_w(input logic [191:0] w);
        for (int i = 0; i < 192; i++) begin
            @(negedge clk);
            weight_en = 1'b1;
            weight    = w[i];
        end
        @(negedge clk);
        weight_en = 1'b0;
        weight    = 1'b0;
    endtask

    // One ivalid cycle then one data cycle per beat.
    task automatic send_beats(input int n, input logic [5:0][31:0] v);
        for (int b = 0; b < n; b++) begin
            @(negedge clk);
            ivalid = 1'b1;
            @(negedge clk);
            ivalid = 1'b0;
            set_din(v);
        end
    endtask

    task automatic expect_result(input string name, input logic [31:0] exp);
        @(negedge clk);
        checks++;
        if (ovalid !== 1'b1 || dout !== exp) begin
            failures++;
            $display("FAIL %s: ovalid=%b dout=%h required ovalid=1 dout=%h",
                     name, ovalid, dout, exp);
        end
        @(negedge clk);
        checks++;
        if (ovalid !== 1'b0 || dout !== exp) begin
            failures++;
            $display("FAIL %s_hold: ovalid=%b dout=%h required ovalid=0 dout=%h",
                     name, ovalid, dout, exp);
        end
    endtask

    function automatic logic [5:0][31:0] all(input logic [31:0] x);
        return {x, x, x, x, x, x};
    endfunction

    task automatic test_reset;
        rstn = 1'b0; ivalid = 1'b0; weight = 1'b0; weight_en = 1'b0;
        set_din(all(32'd0));
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        checks++;
        if (ovalid !== 1'b0 || dout !== 32'd0) begin
            failures++;
            $display("FAIL reset: ovalid=%b dout=%h required 0/0", ovalid, dout);
        end
    endtask

    task automatic test_ones;
        int p0;
        load_w({192{1'b1}});
        p0 = npulse;
        send_beats(32, all(32'd1));
        expect_result("ones", 32'd192);
        checks++;
        if (npulse - p0 != 1) begin
            failures++;
            $display("FAIL ones_pulses: got %0d required 1", npulse - p0);
        end
    endtask

    task automatic test_neg;
        load_w({192{1'b0}});
        send_beats(32, all(32'd3));
        expect_result("neg", 32'hFFFFFDC0);
    endtask

    task automatic test_half;
        logic [191:0] w;
        w = {{96{1'b0}}, {96{1'b1}}};
        load_w(w);
        send_beats(32, all(32'd5));
        expect_result("half_5", 32'd0);
        send_beats(32, {32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1});
        expect_result("half_k", 32'd0);
        for (int i = 0; i < 192; i++) w[i] = i[0];
        load_w(w);
        send_beats(32, {32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1});
        expect_result("alt_k", 32'd96);
    endtask

    task automatic test_wrap;
        load_w({192{1'b1}});
        send_beats(32, all(32'h7FFFFFFF));
        expect_result("wrap", 32'hFFFFFF40);
    endtask

    task automatic test_back_to_back;
        int p0, d0;
        p0 = npulse;
        d0 = ndouble;
        @(negedge clk);
        ivalid = 1'b1;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            set_din(all(i < 32 ? 32'd1 : 32'd2));
            ivalid = (i < 63);
        end
        expect_result("b2b_f2", 32'd384);
        checks++;
        if (npulse - p0 != 2 || ndouble != d0) begin
            failures++;
            $display("FAIL b2b_pulses: got %0d double=%0d required 2 double=0",
                     npulse - p0, ndouble - d0);
        end
        checks++;
        if (res.size() < 2 || res[res.size()-2] !== 32'd192) begin
            failures++;
            $display("FAIL b2b_f1: got %h required %h",
                     res.size() >= 2 ? res[res.size()-2] : 32'hx, 32'd192);
        end
    endtask

    task automatic test_abort_reset;
        send_beats(10, all(32'd9));
        @(negedge clk);
        rstn = 1'b0;
        #1;
        checks++;
        if (ovalid !== 1'b0 || dout !== 32'd0) begin
            failures++;
            $display("FAIL abort_rst_clear: ovalid=%b dout=%h required 0/0",
                     ovalid, dout);
        end
        @(negedge clk);
        rstn = 1'b1;
        load_w({192{1'b1}});
        send_beats(32, all(32'd1));
        expect_result("abort_rst", 32'd192);
    endtask

    task automatic test_abort_wen;
        int p0;
        p0 = npulse;
        send_beats(10, all(32'd7));
        @(negedge clk);
        weight_en = 1'b1;
        weight    = 1'b1;
        @(negedge clk);
        weight_en = 1'b0;
        weight    = 1'b0;
        send_beats(31, all(32'd1));
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (npulse != p0) begin
            failures++;
            $display("FAIL abort_wen_early: pulses=%0d required 0", npulse - p0);
        end
        send_beats(1, all(32'd1));
        expect_result("abort_wen", 32'd192);
    endtask

    initial begin
        test_reset();
        test_ones();
        test_neg();
        test_half();
        test_wrap();
        test_back_to_back();
        test_abort_reset();
        test_abort_wen();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
